div_unit: RTL

- Multi-cycle 32-bit integer divider for DIV/DIVU, sitting beside the ALU in the execute stage.
- Its busy/ready outputs feed the hazard unit, which drives stallE/stallM into the pipeline controller until the quotient and remainder are available.
- Its 64-bit result is written to HI/LO on the write_hilo path.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit_if.sv | 29 ++
 rtl/div_unit_step.sv | 33 +++
 rtl/div_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle execute-stage divider.
// Also decodes the ALU opcodes that select DIV/DIVU.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic [7:0] ALUOP_DIV  = 8'h1A;
  localparam logic [7:0] ALUOP_DIVU = 8'h1B;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
  endfunction

  function automatic logic is_signed_div_op(input logic [7:0] aluop);
    return (aluop == ALUOP_DIV);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute stage and the divider.
// The master drives the request; the slave returns status and the result.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ack;
  logic               annul;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, a, b, ack, annul,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, ack, annul,
    output busy, ready, result
  );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem, dvd} left, trial-subtract the
// divisor and shift the resulting quotient bit into the dividend register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] trial_s;

  // rem < divisor always holds, so WIDTH+1 bits keep the sign of the trial exact
  assign rem_sh_s = {rem_i, dvd_i[WIDTH-1]};
  assign trial_s  = rem_sh_s - {1'b0, dsr_i};

  // Restore on a negative trial, otherwise keep the difference
  always_comb begin
    rem_o = rem_sh_s[WIDTH-1:0];
    dvd_o = {dvd_i[WIDTH-2:0], 1'b0};
    if (!trial_s[WIDTH]) begin
      rem_o = trial_s[WIDTH-1:0];
      dvd_o = {dvd_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh_s[WIDTH-1:0];
      dvd_o = {dvd_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided one bit per cycle and the
// signs are reapplied when the {remainder, quotient} result is loaded.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, ready_q;

  logic [WIDTH-1:0]   step_rem_s, step_dvd_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               a_neg_s, b_neg_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem_s),
    .dvd_o (step_dvd_s)
  );

  assign a_neg_s = bus.signed_div & bus.a[WIDTH-1];
  assign b_neg_s = bus.signed_div & bus.b[WIDTH-1];
  assign a_mag_s = neg_if(bus.a, a_neg_s);
  assign b_mag_s = neg_if(bus.b, b_neg_s);

  // Next-state and datapath update; annul overrides everything and leaves result alone
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    if (bus.annul) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.start && (bus.b != '0)) begin
            rem_d   = '0;
            dvd_d   = a_mag_s;
            dsr_d   = b_mag_s;
            q_neg_d = a_neg_s ^ b_neg_s;
            r_neg_d = a_neg_s;
            cnt_d   = '0;
            state_d = DIV_BUSY;
          end else if (bus.start) begin
            result_d = {bus.a, DIV_BY_ZERO_Q};
            state_d  = DIV_DONE;
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          rem_d = step_rem_s;
          dvd_d = step_dvd_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            result_d = {neg_if(step_rem_s, r_neg_q), neg_if(step_dvd_s, q_neg_q)};
            state_d  = DIV_DONE;
          end else begin
            state_d = DIV_BUSY;
          end
        end
        DIV_DONE: begin
          if (bus.ack) begin
            state_d = DIV_IDLE;
          end else begin
            state_d = DIV_DONE;
          end
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // State, datapath and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      busy_q   <= (state_d == DIV_BUSY);
      ready_q  <= (state_d == DIV_DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule
